// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for a shared serial bus with one outstanding split transaction.
// A split master is handed the bus back with top priority once its slave signals completion.
module serial_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned SEL_WIDTH   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] mbreq,
    output logic [NUM_MASTERS-1:0] mbgrant,
    output logic [NUM_MASTERS-1:0] msplit,
    output logic [SEL_WIDTH-1:0]   msel,
    output logic                   bus_busy,
    input  logic                   split_req,
    input  logic                   split_done,
    output logic                   split_en
);

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] mbgrant_q, mbgrant_d;
    logic [NUM_MASTERS-1:0] msplit_q, msplit_d;
    logic [SEL_WIDTH-1:0]   msel_q, msel_d;
    logic [SEL_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_WIDTH-1:0]   split_id_q, split_id_d;
    logic                   split_pending_q, split_pending_d;
    logic                   done_latched_q, done_latched_d;
    logic                   bus_busy_q, bus_busy_d;

    always_comb begin
        logic                   found;
        logic [NUM_MASTERS-1:0] eligible;
        int unsigned            idx;

        state_d         = state_q;
        mbgrant_d       = mbgrant_q;
        msplit_d        = msplit_q;
        msel_d          = msel_q;
        rr_ptr_d        = rr_ptr_q;
        split_id_d      = split_id_q;
        split_pending_d = split_pending_q;
        done_latched_d  = done_latched_q;
        found           = 1'b0;
        eligible        = '0;
        idx             = 0;

        if (split_pending_q && split_done) begin
            done_latched_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                mbgrant_d = '0;
                if (split_pending_q && done_latched_q) begin
                    // Split return outranks round-robin; if the master gave up, drop the split.
                    if (mbreq[split_id_q]) begin
                        found                 = 1'b1;
                        mbgrant_d[split_id_q] = 1'b1;
                        msel_d                = split_id_q;
                        state_d               = ST_OWNED;
                    end
                    msplit_d        = '0;
                    split_pending_d = 1'b0;
                    done_latched_d  = 1'b0;
                end
                if (!found) begin
                    eligible = mbreq;
                    if (split_pending_d) begin
                        eligible[split_id_q] = 1'b0;
                    end
                    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                        idx = int'(rr_ptr_q) + i;
                        if (idx >= NUM_MASTERS) begin
                            idx = idx - NUM_MASTERS;
                        end
                        if (!found && eligible[idx]) begin
                            found          = 1'b1;
                            mbgrant_d[idx] = 1'b1;
                            msel_d         = SEL_WIDTH'(idx);
                            rr_ptr_d       = (idx == NUM_MASTERS - 1) ? '0 : SEL_WIDTH'(idx + 1);
                            state_d        = ST_OWNED;
                        end
                    end
                end
            end
            ST_OWNED: begin
                if (split_req && !split_pending_q) begin
                    split_pending_d  = 1'b1;
                    split_id_d       = msel_q;
                    msplit_d[msel_q] = 1'b1;
                    done_latched_d   = 1'b0;
                    mbgrant_d        = '0;
                    state_d          = ST_IDLE;
                end else if (!mbreq[msel_q]) begin
                    mbgrant_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                mbgrant_d = '0;
                state_d   = ST_IDLE;
            end
        endcase

        bus_busy_d = |mbgrant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            mbgrant_q       <= '0;
            msplit_q        <= '0;
            msel_q          <= '0;
            rr_ptr_q        <= '0;
            split_id_q      <= '0;
            split_pending_q <= 1'b0;
            done_latched_q  <= 1'b0;
            bus_busy_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            mbgrant_q       <= mbgrant_d;
            msplit_q        <= msplit_d;
            msel_q          <= msel_d;
            rr_ptr_q        <= rr_ptr_d;
            split_id_q      <= split_id_d;
            split_pending_q <= split_pending_d;
            done_latched_q  <= done_latched_d;
            bus_busy_q      <= bus_busy_d;
        end
    end

    assign mbgrant  = mbgrant_q;
    assign msplit   = msplit_q;
    assign msel     = msel_q;
    assign bus_busy = bus_busy_q;
    assign split_en = ~split_pending_q;

    grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(mbgrant_q));

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter (3 masters): the stimulus queues expected outputs,
// and a monitor on the falling edge pops and compares them.
module tb_serial_bus_arbiter;

    typedef struct packed {
        logic [2:0] grant;
        logic [2:0] msplit;
        logic [1:0] msel;
        logic       busy;
        logic       split_en;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mbreq = '0;
    logic [2:0] mbgrant;
    logic [2:0] msplit;
    logic [1:0] msel;
    logic       bus_busy;
    logic       split_req = 1'b0;
    logic       split_done = 1'b0;
    logic       split_en;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    serial_bus_arbiter #(
        .NUM_MASTERS(3),
        .SEL_WIDTH  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mbreq     (mbreq),
        .mbgrant   (mbgrant),
        .msplit    (msplit),
        .msel      (msel),
        .bus_busy  (bus_busy),
        .split_req (split_req),
        .split_done(split_done),
        .split_en  (split_en)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs; expectation describes outputs after the coming edge.
    task automatic step(input logic r, input logic [2:0] req, input logic sr, input logic sd,
                        input logic [2:0] g, input logic [2:0] ms, input logic [1:0] sel,
                        input logic en, input string tag);
        exp_t e;
        rst        = r;
        mbreq      = req;
        split_req  = sr;
        split_done = sd;
        @(posedge clk);
        e.grant    = g;
        e.msplit   = ms;
        e.msel     = sel;
        e.busy     = |g;
        e.split_en = en;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if ({mbgrant, msplit, msel, bus_busy, split_en} !== e) begin
                errors++;
                $display("FAIL %s: got grant=%b msplit=%b msel=%0d busy=%b split_en=%b, want grant=%b msplit=%b msel=%0d busy=%b split_en=%b",
                         t, mbgrant, msplit, msel, bus_busy, split_en,
                         e.grant, e.msplit, e.msel, e.busy, e.split_en);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //    rst  req     sr  sd   grant   msplit  msel  en
        step(1, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 1, "reset0");
        step(1, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 1, "reset1");
        // round-robin with all requesting
        step(0, 3'b111, 0, 0, 3'b001, 3'b000, 2'd0, 1, "rr_g0");
        step(0, 3'b111, 0, 0, 3'b001, 3'b000, 2'd0, 1, "rr_hold0");
        step(0, 3'b110, 0, 0, 3'b000, 3'b000, 2'd0, 1, "rr_idle0");
        step(0, 3'b111, 0, 0, 3'b010, 3'b000, 2'd1, 1, "rr_g1");
        step(0, 3'b101, 0, 0, 3'b000, 3'b000, 2'd1, 1, "rr_idle1");
        step(0, 3'b111, 0, 0, 3'b100, 3'b000, 2'd2, 1, "rr_g2");
        step(0, 3'b011, 0, 0, 3'b000, 3'b000, 2'd2, 1, "rr_idle2");
        step(0, 3'b111, 0, 0, 3'b001, 3'b000, 2'd0, 1, "rr_g0_again");
        step(0, 3'b110, 0, 0, 3'b000, 3'b000, 2'd0, 1, "rr_idle3");
        // walk rr_ptr to 0, then lone master 2 wraps it
        step(0, 3'b010, 0, 0, 3'b010, 3'b000, 2'd1, 1, "solo_g1");
        step(0, 3'b000, 0, 0, 3'b000, 3'b000, 2'd1, 1, "solo_idle1");
        step(0, 3'b100, 0, 0, 3'b100, 3'b000, 2'd2, 1, "solo_g2a");
        step(0, 3'b000, 0, 0, 3'b000, 3'b000, 2'd2, 1, "solo_idle2");
        step(0, 3'b100, 0, 0, 3'b100, 3'b000, 2'd2, 1, "solo_g2_ptr0");
        step(0, 3'b000, 0, 0, 3'b000, 3'b000, 2'd2, 1, "solo_idle3");
        step(0, 3'b011, 0, 0, 3'b001, 3'b000, 2'd0, 1, "wrap_g0");
        // split master 0, master 1 takes over
        step(0, 3'b011, 1, 0, 3'b000, 3'b001, 2'd0, 0, "split0");
        step(0, 3'b011, 0, 0, 3'b010, 3'b001, 2'd1, 0, "split_g1");
        step(0, 3'b111, 1, 0, 3'b010, 3'b001, 2'd1, 0, "second_split_ignored");
        step(0, 3'b111, 0, 1, 3'b010, 3'b001, 2'd1, 0, "done_no_preempt");
        step(0, 3'b111, 0, 0, 3'b010, 3'b001, 2'd1, 0, "done_hold");
        step(0, 3'b101, 0, 0, 3'b000, 3'b001, 2'd1, 0, "release1");
        step(0, 3'b101, 0, 0, 3'b001, 3'b000, 2'd0, 1, "split_return0");
        step(0, 3'b100, 0, 0, 3'b000, 3'b000, 2'd0, 1, "return_release");
        step(0, 3'b110, 0, 0, 3'b100, 3'b000, 2'd2, 1, "rr_ptr_unmoved");
        step(0, 3'b000, 0, 0, 3'b000, 3'b000, 2'd2, 1, "idle_after2");
        // abandoned split: master 0 drops request before return
        step(0, 3'b001, 0, 0, 3'b001, 3'b000, 2'd0, 1, "ab_g0");
        step(0, 3'b001, 1, 0, 3'b000, 3'b001, 2'd0, 0, "ab_split");
        step(0, 3'b000, 0, 1, 3'b000, 3'b001, 2'd0, 0, "ab_done");
        step(0, 3'b010, 0, 0, 3'b010, 3'b000, 2'd1, 1, "ab_abandon_g1");
        step(0, 3'b010, 0, 1, 3'b010, 3'b000, 2'd1, 1, "done_no_pending");
        step(0, 3'b010, 1, 0, 3'b000, 3'b010, 2'd1, 0, "split1");
        step(0, 3'b010, 0, 0, 3'b000, 3'b010, 2'd1, 0, "split1_not_returned");
        step(0, 3'b011, 0, 0, 3'b001, 3'b010, 2'd0, 0, "split1_g0");
        // reset while owned with a split pending
        step(1, 3'b011, 0, 0, 3'b000, 3'b000, 2'd0, 1, "mid_reset");
        step(0, 3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 1, "post_reset_idle");
        step(0, 3'b010, 0, 0, 3'b010, 3'b000, 2'd1, 1, "post_reset_g1");
        step(0, 3'b000, 0, 0, 3'b000, 3'b000, 2'd1, 1, "post_reset_release");

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
